// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with a pending-write scoreboard,
// EX/WB operand bypass and ID-stage stall generation.
//
// Entry 0 reads as zero and is never written. Each read port resolves its
// operand combinationally from EX forwarding, WB forwarding, the scoreboard
// and the array, in that order.
//
// Build option: define REGFILE_WB_BYPASS_EN to forward the writeback value
// to same-cycle readers. Without it, such a reader stalls for one cycle and
// picks the value up from the array on the following cycle.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wb_en,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [DATA_W-1:0]            wb_data,
  input  logic                         ex_en,
  input  logic [ADDR_W-1:0]            ex_addr,
  input  logic                         ex_valid,
  input  logic [DATA_W-1:0]            ex_data,
  input  logic                         issue_en,
  input  logic [ADDR_W-1:0]            issue_addr,
  input  logic                         sb_clear,
  input  logic [NUM_READ-1:0]          rd_en,
  input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
  output logic [NUM_READ*DATA_W-1:0]   rd_data,
  output logic [(2**ADDR_W)-1:0]       pending,
  output logic                         stall
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    pend_q;
  logic [DEPTH-1:0]    pend_d;
  logic [NUM_READ-1:0] port_stall;
  logic                wb_wr;
  logic                issue_set;

  // Register 0 is constant zero, so writes to it are dropped.
  assign wb_wr     = wb_en && (wb_addr != '0);

  // A new producer is only recorded when ID actually issues.
  assign issue_set = issue_en && !stall && (issue_addr != '0);

  // Register array: cleared by reset, written from the WB path.
  // NOTE: the array must read as zero straight out of reset, so every entry
  // sits on the asynchronous reset; this rules out mapping it to a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        // NOTE: state elements always take non-blocking assignments so every
        // flop samples pre-edge values, regardless of block ordering.
        mem[i] <= '0;
      end
    end else if (wb_wr) begin
      mem[wb_addr] <= wb_data;
    end
  end

  // Scoreboard next state: clear beats everything; a set beats a same-cycle
  // writeback clear because the issuing instruction is the younger producer.
  always_comb begin
    // NOTE: start from a full default so no path leaves pend_d unassigned,
    // which would otherwise infer a latch.
    pend_d = pend_q;
    if (sb_clear) begin
      pend_d = '0;
    end else begin
      if (wb_en) begin
        pend_d[wb_addr] = 1'b0;
      end
      if (issue_set) begin
        pend_d[issue_addr] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;

  // Per-port operand resolution.
  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              stl;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    // Forwarding priority: EX, then WB, then scoreboard, then array.
    // Reset forces the port quiet even though EX/WB inputs may be live.
    always_comb begin
      data = '0;
      stl  = 1'b0;
      if (rst_n && rd_en[p] && (addr != '0)) begin
        if (ex_en && (addr == ex_addr)) begin
          if (ex_valid) begin
            data = ex_data;
          end else begin
            stl = 1'b1;
          end
`ifdef REGFILE_WB_BYPASS_EN
        end else if (wb_en && (addr == wb_addr)) begin
          data = wb_data;
`else
        end else if (wb_en && (addr == wb_addr)) begin
          stl = 1'b1;
`endif
        end else if (pend_q[addr]) begin
          stl = 1'b1;
        end else begin
          data = mem[addr];
        end
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data;
    assign port_stall[p]               = stl;
  end

  assign stall = |port_stall;

endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb (4 read ports, 64-bit data, 64 entries).
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural register-file model kept in plain arrays.
module tb_regfile_sb;

  localparam int DW    = 64;
  localparam int AW    = 6;
  localparam int NR    = 4;
  localparam int DEPTH = 64;

`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic             ex_en;
  logic [AW-1:0]    ex_addr;
  logic             ex_valid;
  logic [DW-1:0]    ex_data;
  logic             issue_en;
  logic [AW-1:0]    issue_addr;
  logic             sb_clear;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [DEPTH-1:0] pending;
  logic             stall;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state.
  logic [DW-1:0] ref_mem  [DEPTH];
  bit            ref_pend [DEPTH];

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .ex_en      (ex_en),
    .ex_addr    (ex_addr),
    .ex_valid   (ex_valid),
    .ex_data    (ex_data),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .sb_clear   (sb_clear),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .pending    (pending),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DEPTH-1:0] ref_pend_vec();
    logic [DEPTH-1:0] v = '0;
    for (int a = 1; a < DEPTH; a++) v[a] = ref_pend[a];
    return v;
  endfunction

  // Expected operand for one port from the current inputs and model state.
  function automatic void ref_port(input int p, output logic [DW-1:0] d, output bit s);
    int a = int'(rd_addr[p*AW +: AW]);
    d = '0;
    s = 1'b0;
    if (!rd_en[p] || a == 0) return;
    if (ex_en && a == int'(ex_addr)) begin
      if (ex_valid) d = ex_data; else s = 1'b1;
      return;
    end
    if (wb_en && a == int'(wb_addr)) begin
      if (BYPASS) d = wb_data; else s = 1'b1;
      return;
    end
    if (ref_pend[a]) begin
      s = 1'b1;
      return;
    end
    d = ref_mem[a];
  endfunction

  function automatic bit ref_stall();
    logic [DW-1:0] d;
    bit s, any = 1'b0;
    for (int p = 0; p < NR; p++) begin
      ref_port(p, d, s);
      any |= s;
    end
    return any;
  endfunction

  task automatic ref_reset();
    for (int a = 0; a < DEPTH; a++) begin
      ref_mem[a]  = '0;
      ref_pend[a] = 1'b0;
    end
  endtask

  // Apply one clock edge worth of architectural effect to the model.
  task automatic ref_update();
    bit st = ref_stall();
    if (wb_en && wb_addr != 0) ref_mem[wb_addr] = wb_data;
    if (sb_clear) begin
      for (int a = 0; a < DEPTH; a++) ref_pend[a] = 1'b0;
    end else begin
      if (wb_en) ref_pend[wb_addr] = 1'b0;
      if (issue_en && !st && issue_addr != 0) ref_pend[issue_addr] = 1'b1;
    end
  endtask

  // Compare all outputs at the falling edge.
  task automatic sample();
    logic [DW-1:0] d;
    bit s;
    @(negedge clk);
    for (int p = 0; p < NR; p++) begin
      ref_port(p, d, s);
      check($sformatf("rd_data[%0d]", p), rd_data[p*DW +: DW], d);
    end
    check("stall", {63'd0, stall}, {63'd0, ref_stall()});
    check("pending", pending, ref_pend_vec());
  endtask

  task automatic advance();
    ref_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_en = 0; wb_addr = '0; wb_data = '0;
    ex_en = 0; ex_addr = '0; ex_valid = 0; ex_data = '0;
    issue_en = 0; issue_addr = '0; sb_clear = 0;
    rd_en = '0; rd_addr = '0;
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH-1));
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic random_inputs();
    wb_en      = ($urandom_range(0, 2) == 0);
    wb_addr    = rand_addr();
    wb_data    = {$urandom, $urandom};
    ex_en      = ($urandom_range(0, 3) == 0);
    ex_addr    = rand_addr();
    ex_valid   = $urandom_range(0, 1) == 1;
    ex_data    = {$urandom, $urandom};
    issue_en   = ($urandom_range(0, 2) == 0);
    issue_addr = rand_addr();
    sb_clear   = ($urandom_range(0, 40) == 0);
    for (int p = 0; p < NR; p++) begin
      rd_en[p] = ($urandom_range(0, 3) != 0);
      rd_addr[p*AW +: AW] = rand_addr();
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    ref_reset();
    #12;
    // Reset state, ports 0/1 reading r3/r7.
    set_port(0, 6'd3);
    set_port(1, 6'd7);
    #1;
    check("reset rd0", rd_data[0 +: DW], '0);
    check("reset rd1", rd_data[DW +: DW], '0);
    check("reset stall", {63'd0, stall}, 64'd0);
    check("reset pending", pending, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sample(); advance();

    // Put a value in r5, then reset in the middle of a second write to r5.
    wb_en = 1; wb_addr = 6'd5; wb_data = 64'hBEEF;
    sample(); advance();
    wb_data = 64'hDEAD;
    set_port(0, 6'd5);
    ex_en = 1; ex_addr = 6'd7; ex_valid = 1; ex_data = 64'h77;
    #2 rst_n = 1'b0;
    #1;
    check("in-reset rd0", rd_data[0 +: DW], '0);
    check("in-reset rd1", rd_data[DW +: DW], '0);
    check("in-reset stall", {63'd0, stall}, 64'd0);
    check("in-reset pending", pending, '0);
    ref_reset();
    @(posedge clk); #1;
    idle_inputs();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    set_port(0, 6'd5);
    sample();
    check("r5 after reset", rd_data[0 +: DW], '0);
    advance();

    // Writeback r4 with same-cycle read.
    idle_inputs();
    wb_en = 1; wb_addr = 6'd4; wb_data = 64'h1234_5678;
    set_port(0, 6'd4);
    sample();
    if (BYPASS) check("wb bypass r4", rd_data[0 +: DW], 64'h1234_5678);
    else        check("wb no-bypass stall", {63'd0, stall}, 64'd1);
    advance();
    wb_en = 0;
    sample();
    check("r4 next cycle", rd_data[0 +: DW], 64'h1234_5678);
    check("r4 next stall", {63'd0, stall}, 64'd0);
    advance();

    // EX forwarding, valid then not yet valid.
    idle_inputs();
    ex_en = 1; ex_addr = 6'd9; ex_valid = 1; ex_data = 64'hAA;
    set_port(0, 6'd9);
    sample();
    check("ex fwd r9", rd_data[0 +: DW], 64'hAA);
    advance();
    ex_valid = 0;
    sample();
    check("ex not valid stall", {63'd0, stall}, 64'd1);
    check("ex not valid data", rd_data[0 +: DW], '0);
    advance();

    // Load scoreboard on r6.
    idle_inputs();
    issue_en = 1; issue_addr = 6'd6;
    sample(); advance();
    issue_en = 0;
    check("pending[6] set", {63'd0, pending[6]}, 64'd1);
    set_port(0, 6'd6);
    for (int c = 0; c < 3; c++) begin
      sample();
      check("r6 pending stall", {63'd0, stall}, 64'd1);
      advance();
    end
    wb_en = 1; wb_addr = 6'd6; wb_data = 64'h55;
    sample();
    if (BYPASS) check("r6 wb bypass", rd_data[0 +: DW], 64'h55);
    else        check("r6 wb stall", {63'd0, stall}, 64'd1);
    advance();
    wb_en = 0;
    sample();
    check("pending[6] clear", {63'd0, pending[6]}, 64'd0);
    check("r6 value", rd_data[0 +: DW], 64'h55);
    advance();

    // Same-cycle issue and writeback on r8; issue/write of r0.
    idle_inputs();
    issue_en = 1; issue_addr = 6'd8;
    wb_en = 1; wb_addr = 6'd8; wb_data = 64'h88;
    sample(); advance();
    check("set beats clear r8", {63'd0, pending[8]}, 64'd1);
    issue_addr = 6'd0;
    wb_addr = 6'd0; wb_data = 64'hFFFF;
    sample(); advance();
    check("pending[0] zero", {63'd0, pending[0]}, 64'd0);
    idle_inputs();
    set_port(0, 6'd0);
    sample();
    check("r0 reads zero", rd_data[0 +: DW], '0);
    advance();

    // All four ports read r63.
    idle_inputs();
    wb_en = 1; wb_addr = 6'd63; wb_data = 64'h0123_4567_89AB_CDEF;
    sample(); advance();
    wb_en = 0;
    for (int p = 0; p < NR; p++) set_port(p, 6'd63);
    sample();
    for (int p = 0; p < NR; p++)
      check($sformatf("r63 port%0d", p), rd_data[p*DW +: DW], 64'h0123_4567_89AB_CDEF);
    advance();

    // Scoreboard clear.
    idle_inputs();
    issue_en = 1; issue_addr = 6'd40;
    sample(); advance();
    issue_en = 0;
    check("pending[40] set", {63'd0, pending[40]}, 64'd1);
    sb_clear = 1;
    sample(); advance();
    sb_clear = 0;
    check("sb_clear all", pending, '0);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      random_inputs();
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
